keccak_stream_driver: RTL and testbench

Host-side counterpart of the keccak core's w-bit streaming interface. Accepts a job (mode, message length, output length) and host message words, then emits the header word and message words into the core's active-low-valid input stream. Collects the core's output words through an active-low ready, trims the final word, and presents the digest to the host on a valid/ready stream. Sits between the system bus adapter and the keccak top.

---
 rtl/keccak_stream_driver_pkg.sv | 33 +++
 rtl/keccak_stream_driver_skid.sv | 82 ++++++++
 rtl/keccak_stream_driver.sv | 234 +++++++++++++++++++++++
 tb/tb_keccak_stream_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_stream_driver_pkg.sv
// Shared definitions for the keccak stream driver: supported operation modes,
// header field positions and the driver FSM state type.
// Compile options: none (the optional stall watchdog, KECCAK_DRV_TIMEOUT_EN,
// lives in keccak_stream_driver.sv).
package keccak_stream_driver_pkg;

  // Stream word width of the keccak core
  localparam int KECCAK_W = 64;

  // Header word layout: [63:62] mode, [61:32] message length, [31:0] output length
  localparam int HDR_MODE_MSB = KECCAK_W - 1;
  localparam int HDR_LEN_LSB  = 32;
  localparam int HDR_OUTLEN_W = 32;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'b00,
    MODE_SHAKE256 = 2'b01
  } keccak_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_MSG,
    ST_OUT,
    ST_DRAIN
  } drv_state_t;

  // Codes 2'b10 and 2'b11 are reserved and must be rejected
  function automatic logic mode_supported(input logic [1:0] m);
    return (m == MODE_SHAKE128) || (m == MODE_SHAKE256);
  endfunction

endpackage

// File: rtl/keccak_stream_driver_skid.sv
// stream_skid_buffer: 2-entry buffer between the core's output stream and the
// host digest stream. The head entry drives the outputs directly, so
// out_valid/out_data are registered and a pushed word is visible one cycle
// later. A simultaneous push and pop is accepted in any occupancy.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   flush         synchronous clear of both entries
//   in_valid      push request (caller must not push while full without a pop)
//   in_data       pushed word
//   full          both entries occupied
//   out_valid     head entry valid
//   out_ready     consumer accepts head entry
//   out_data      head entry contents
module stream_skid_buffer #(
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          full,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          head_valid;
  logic          tail_valid;
  logic [DW-1:0] head_data;
  logic [DW-1:0] tail_data;
  logic          pop;

  assign pop       = head_valid && out_ready;
  assign full      = tail_valid;
  assign out_valid = head_valid;
  assign out_data  = head_data;

  // Tail always shifts into head on a pop; a push fills the first free slot
  // after that shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (!head_valid) begin
            head_data  <= in_data;
            head_valid <= 1'b1;
          end else begin
            tail_data  <= in_data;
            tail_valid <= 1'b1;
          end
        end
        2'b01: begin
          head_data  <= tail_data;
          head_valid <= tail_valid;
          tail_valid <= 1'b0;
        end
        2'b11: begin
          if (tail_valid) begin
            head_data <= tail_data;
            tail_data <= in_data;
          end else begin
            head_data <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/keccak_stream_driver.sv
// keccak_stream_driver: host-side driver for the keccak core's streaming
// interface. Latches a job, sends a header word and the host's message words
// to the core, then collects the core's output words through a 2-entry skid
// buffer, trims the final word to the requested bit length and presents the
// digest on a valid/ready stream.
// Compile option: define KECCAK_DRV_TIMEOUT_EN to add a stall watchdog that
// aborts the job after TIMEOUT_CYC consecutive cycles without a core transfer.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start, mode, in_len, out_len  job request (sampled in IDLE only)
//   busy, err                     job in progress, one-cycle error pulse
//   msg_valid/msg_ready/msg_data  host message stream
//   core_valid_n/core_ready/core_din    core input stream (active-low valid)
//   core_valid/core_ready_n/core_dout   core output stream (active-low ready)
//   dig_valid/dig_ready/dig_data/dig_last  host digest stream
module keccak_stream_driver
  import keccak_stream_driver_pkg::*;
#(
  parameter int W           = 64,
  parameter int LEN_W       = 30,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] in_len,
  input  logic [31:0]      out_len,
  output logic             busy,
  output logic             err,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [W-1:0]     msg_data,
  output logic             core_valid_n,
  input  logic             core_ready,
  output logic [W-1:0]     core_din,
  input  logic             core_valid,
  output logic             core_ready_n,
  input  logic [W-1:0]     core_dout,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [W-1:0]     dig_data,
  output logic             dig_last
);

  // ceil(len/8) fits in LEN_W-2 bits; ceil(out_len/64) fits in 27 bits
  localparam int MSG_CNT_W = LEN_W - 2;
  localparam int OUT_CNT_W = 27;
  localparam int TAIL_W    = $clog2(W);

  drv_state_t           state;
  logic [1:0]           mode_r;
  logic [LEN_W-1:0]     len_r;
  logic [31:0]          out_len_r;
  logic [MSG_CNT_W-1:0] msg_left;
  logic [OUT_CNT_W-1:0] out_left;
  logic [MSG_CNT_W-1:0] in_words;
  logic [OUT_CNT_W-1:0] out_words;
  logic [W-1:0]         header;
  logic [W-1:0]         tail_mask;
  logic [W-1:0]         push_word;
  logic [W:0]           skid_out;
  logic                 start_bad;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 push_last;
  logic                 buf_full;
  logic                 dig_pop;
  logic                 timeout_hit;

  assign in_words  = MSG_CNT_W'(({1'b0, in_len} + (LEN_W+1)'(7)) >> 3);
  assign out_words = OUT_CNT_W'(({1'b0, out_len} + 33'd63) >> 6);
  assign start_bad = !mode_supported(mode) || (out_len == 32'd0);

  assign in_xfer   = !core_valid_n && core_ready;
  assign out_xfer  = core_valid && !core_ready_n;
  assign dig_pop   = dig_valid && dig_ready;
  assign push_last = (out_left == OUT_CNT_W'(1));

  // Header is built from the latched job so it stays stable while HDR waits
  always_comb begin
    header = '0;
    header[HDR_MODE_MSB -: 2]       = mode_r;
    header[HDR_LEN_LSB +: LEN_W]    = len_r;
    header[HDR_OUTLEN_W-1:0]        = out_len_r;
  end

  // Only the final word is trimmed; a bit count that is a multiple of W keeps
  // the whole word.
  always_comb begin
    if (out_len_r[TAIL_W-1:0] == '0) begin
      tail_mask = '1;
    end else begin
      tail_mask = (W'(1) << out_len_r[TAIL_W-1:0]) - W'(1);
    end
    push_word = push_last ? (core_dout & tail_mask) : core_dout;
  end

  // Stream handshakes decode straight from the state register; in MSG the host
  // word is passed through to the core without adding a cycle.
  always_comb begin
    core_valid_n = 1'b1;
    core_din     = '0;
    msg_ready    = 1'b0;
    core_ready_n = 1'b1;
    case (state)
      ST_HDR: begin
        core_valid_n = 1'b0;
        core_din     = header;
      end
      ST_MSG: begin
        msg_ready    = core_ready;
        core_valid_n = !msg_valid;
        core_din     = msg_data;
      end
      ST_OUT: begin
        core_ready_n = buf_full;
      end
      default: begin
      end
    endcase
  end

`ifdef KECCAK_DRV_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stalling;

  assign stalling    = (state inside {ST_HDR, ST_MSG, ST_OUT}) && !in_xfer && !out_xfer;
  assign timeout_hit = stalling && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

  // Counts consecutive stalled cycles; any core transfer or leaving the active
  // states restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!stalling || timeout_hit) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Job sequencing: accept or reject in IDLE, then header, message words,
  // output collection and finally draining the buffer to the host.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      mode_r    <= '0;
      len_r     <= '0;
      out_len_r <= '0;
      msg_left  <= '0;
      out_left  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_bad) begin
              err <= 1'b1;
            end else begin
              mode_r    <= mode;
              len_r     <= in_len;
              out_len_r <= out_len;
              msg_left  <= in_words;
              out_left  <= out_words;
              busy      <= 1'b1;
              state     <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (in_xfer) begin
            state <= (msg_left != '0) ? ST_MSG : ST_OUT;
          end
        end
        ST_MSG: begin
          if (in_xfer) begin
            msg_left <= msg_left - MSG_CNT_W'(1);
            if (msg_left == MSG_CNT_W'(1)) begin
              state <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_xfer) begin
            out_left <= out_left - OUT_CNT_W'(1);
            if (push_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dig_pop && dig_last) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (timeout_hit) begin
        err   <= 1'b1;
        busy  <= 1'b0;
        state <= ST_IDLE;
      end
    end
  end

  stream_skid_buffer #(
    .DW(W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (timeout_hit),
    .in_valid (out_xfer),
    .in_data  ({push_last, push_word}),
    .full     (buf_full),
    .out_valid(dig_valid),
    .out_ready(dig_ready),
    .out_data (skid_out)
  );

  assign dig_last = skid_out[W];
  assign dig_data = skid_out[W-1:0];

endmodule

// File: tb/tb_keccak_stream_driver.sv
// Testbench for keccak_stream_driver. Plays both the host and the keccak core
// with randomized handshakes, and compares every transferred word against a
// queue-based model of the job (header, message words, trimmed digest).
`timescale 1ns/1ps
module tb_keccak_stream_driver;

  localparam int W     = 64;
  localparam int LEN_W = 30;
  localparam int TO    = 16;
`ifdef KECCAK_DRV_TIMEOUT_EN
  localparam int HOLD_PCT = 60;
`else
  localparam int HOLD_PCT = 10;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [LEN_W-1:0] in_len = '0;
  logic [31:0]      out_len = '0;
  logic             busy, err;
  logic             msg_valid = 1'b0;
  logic             msg_ready;
  logic [W-1:0]     msg_data = '0;
  logic             core_valid_n;
  logic             core_ready = 1'b0;
  logic [W-1:0]     core_din;
  logic             core_valid = 1'b0;
  logic             core_ready_n;
  logic [W-1:0]     core_dout = '0;
  logic             dig_valid;
  logic             dig_ready = 1'b0;
  logic [W-1:0]     dig_data;
  logic             dig_last;

  always #5 clk = ~clk;

  keccak_stream_driver #(
    .W(W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_len(in_len),
    .out_len(out_len), .busy(busy), .err(err),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .core_valid_n(core_valid_n), .core_ready(core_ready), .core_din(core_din),
    .core_valid(core_valid), .core_ready_n(core_ready_n), .core_dout(core_dout),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .dig_last(dig_last)
  );

  typedef struct {
    logic [1:0]  mode;
    int unsigned in_len;
    int unsigned out_len;
    bit          reject;
    logic [63:0] hdr;
    int          in_words;
    int          out_words;
    int          core_rdy_pct;
    int          dig_rdy_pct;
  } job_rec;

  job_rec jobs[$];
  int vec_count  = 0;
  int miss_count = 0;

  function automatic job_rec mk_job(input logic [1:0] m, input int unsigned il,
                                    input int unsigned ol, input bit rej,
                                    input logic [63:0] h, input int iw, input int ow,
                                    input int cp, input int dp);
    job_rec r;
    r.mode = m; r.in_len = il; r.out_len = ol; r.reject = rej; r.hdr = h;
    r.in_words = iw; r.out_words = ow; r.core_rdy_pct = cp; r.dig_rdy_pct = dp;
    return r;
  endfunction

  // Keep only the low (out_len mod 64) bits of the final word, or all of them
  function automatic logic [63:0] trim_word(input logic [63:0] w, input int unsigned ol);
    int unsigned keep;
    keep = ol % 64;
    if (keep == 0) return w;
    return w & ((64'd1 << keep) - 64'd1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_msg_ready"}, msg_ready, 0);
    checkOutput({tag, "_core_valid_n"}, core_valid_n, 1);
    checkOutput({tag, "_core_ready_n"}, core_ready_n, 1);
    checkOutput({tag, "_core_din"}, core_din, 0);
    checkOutput({tag, "_dig_valid"}, dig_valid, 0);
    checkOutput({tag, "_dig_last"}, dig_last, 0);
    checkOutput({tag, "_dig_data"}, dig_data, 0);
  endtask

  // Presents a job for one clock edge; returns at the following negedge
  task automatic applyStimulus(input job_rec r);
    @(negedge clk);
    mode    = r.mode;
    in_len  = LEN_W'(r.in_len);
    out_len = r.out_len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_job(input job_rec r, input int idx);
    logic [63:0] msg_q[$];
    logic [63:0] exp_dig[$];
    logic [63:0] core_q[$];
    logic [63:0] w;
    int in_seen = 0, msg_sent = 0, core_sent = 0, dig_seen = 0, occ = 0, cyc = 0;
    bit done = 0, saw_err = 0, msg_clr = 0, core_clr = 0;
    string tag;
    tag = $sformatf("job%0d", idx);
    for (int i = 0; i < r.in_words; i++) msg_q.push_back({$urandom, $urandom});
    for (int i = 0; i < r.out_words; i++) begin
      w = {$urandom, $urandom};
      core_q.push_back(w);
      exp_dig.push_back((i == r.out_words - 1) ? trim_word(w, r.out_len) : w);
    end
    applyStimulus(r);
    #1;
    if (r.reject) begin
      checkOutput({tag, "_reject_err"}, err, 1);
      checkOutput({tag, "_reject_busy"}, busy, 0);
      checkOutput({tag, "_reject_core_valid_n"}, core_valid_n, 1);
      @(negedge clk); #1;
      checkOutput({tag, "_err_pulse_end"}, err, 0);
      checkOutput({tag, "_reject_idle_core_valid_n"}, core_valid_n, 1);
      return;
    end
    checkOutput({tag, "_busy_set"}, busy, 1);
    checkOutput({tag, "_accept_err"}, err, 0);
    while (!done && cyc < 4000) begin
      cyc++;
      if (msg_clr) msg_valid = 1'b0;
      if (core_clr) core_valid = 1'b0;
      msg_clr = 0; core_clr = 0;
      core_ready = ($urandom_range(99) < r.core_rdy_pct);
      dig_ready  = ($urandom_range(99) < r.dig_rdy_pct);
      // A stray invalid start while busy must be ignored
      start   = ($urandom_range(7) == 0);
      mode    = 2'b10;
      out_len = 32'd0;
      if (!msg_valid && msg_sent < r.in_words && $urandom_range(99) < 70) begin
        msg_valid = 1'b1;
        msg_data  = msg_q[msg_sent];
      end
      if (!core_valid && in_seen == r.in_words + 1 && core_sent < r.out_words &&
          $urandom_range(99) < 75) begin
        core_valid = 1'b1;
        core_dout  = core_q[core_sent];
      end
      #1;
      if (err) saw_err = 1;
      if (!core_valid_n && core_ready) begin
        if (in_seen > r.in_words)
          checkOutput({tag, "_core_in_count"}, in_seen + 1, r.in_words + 1);
        else
          checkOutput($sformatf("%s_core_in[%0d]", tag, in_seen), core_din,
                      (in_seen == 0) ? r.hdr : msg_q[in_seen - 1]);
        in_seen++;
      end
      if (msg_valid && msg_ready) begin
        msg_sent++;
        msg_clr = 1;
      end
      checkOutput({tag, "_dig_valid_vs_occupancy"}, dig_valid, (occ != 0));
      if (occ == 2) checkOutput({tag, "_core_ready_n_full"}, core_ready_n, 1);
      if (core_valid && !core_ready_n) begin
        occ++;
        core_sent++;
        core_clr = 1;
      end
      if (dig_valid && dig_ready) begin
        if (dig_seen < r.out_words) begin
          checkOutput($sformatf("%s_dig_data[%0d]", tag, dig_seen), dig_data, exp_dig[dig_seen]);
          checkOutput($sformatf("%s_dig_last[%0d]", tag, dig_seen), dig_last,
                      (dig_seen == r.out_words - 1));
          if (dig_seen == r.out_words - 1) done = 1;
        end else begin
          checkOutput({tag, "_dig_count"}, dig_seen + 1, r.out_words);
        end
        dig_seen++;
        occ--;
      end
      if (done) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) checkOutput({tag, "_job_timeout"}, 0, 1);
    #1;
    checkOutput({tag, "_busy_cleared"}, busy, 0);
    checkOutput({tag, "_dig_valid_after"}, dig_valid, 0);
    checkOutput({tag, "_core_in_words"}, in_seen, r.in_words + 1);
    checkOutput({tag, "_host_msg_words"}, msg_sent, r.in_words);
    checkOutput({tag, "_core_out_words"}, core_sent, r.out_words);
    checkOutput({tag, "_no_err_while_busy"}, saw_err, 0);
    msg_valid = 1'b0; core_valid = 1'b0; core_ready = 1'b0; dig_ready = 1'b0;
  endtask

  initial begin
    // mode, in_len, out_len, reject, header, in_words, out_words, core%, dig%
    jobs.push_back(mk_job(2'b00, 0,  256,  0, 64'h0000_0000_0000_0100, 0, 4,  100, 100));
    jobs.push_back(mk_job(2'b01, 20, 100,  0, 64'h4000_0014_0000_0064, 3, 2,  70,  70));
    jobs.push_back(mk_job(2'b10, 8,  64,   1, 64'h0, 0, 0, 0, 0));
    jobs.push_back(mk_job(2'b00, 8,  0,    1, 64'h0, 0, 0, 0, 0));
    jobs.push_back(mk_job(2'b11, 0,  64,   1, 64'h0, 0, 0, 0, 0));
    jobs.push_back(mk_job(2'b00, 1,  1,    0, 64'h0000_0001_0000_0001, 1, 1,  60,  60));
    jobs.push_back(mk_job(2'b01, 64, 1024, 0, 64'h4000_0040_0000_0400, 8, 16, 50,  50));
    jobs.push_back(mk_job(2'b00, 17, 65,   0, 64'h0000_0011_0000_0041, 3, 2,  80,  HOLD_PCT));
    jobs.push_back(mk_job(2'b01, 8,  64,   0, 64'h4000_0008_0000_0040, 1, 1,  50,  40));
    jobs.push_back(mk_job(2'b01, 0,  1024, 0, 64'h4000_0000_0000_0400, 0, 16, 90,  HOLD_PCT));

    #3;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < jobs.size(); i++) run_job(jobs[i], i);

    // Reset in MSG after the header and 2 of 5 message words
    applyStimulus(mk_job(2'b00, 40, 128, 0, 64'h0, 5, 2, 0, 0));
    core_ready = 1'b1;
    msg_valid  = 1'b1;
    msg_data   = 64'h0123_4567_89ab_cdef;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midjob_busy", busy, 1);
    checkOutput("midjob_msg_ready", msg_ready, 1);
    rst = 1'b0;
    #1;
    check_reset_values("midjob_reset");
    msg_valid = 1'b0; core_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_job(mk_job(2'b00, 40, 128, 0, 64'h0000_0028_0000_0080, 5, 2, 70, 70), 100);

`ifdef KECCAK_DRV_TIMEOUT_EN
    begin
      int waited = 0;
      applyStimulus(mk_job(2'b00, 8, 64, 0, 64'h0, 1, 1, 0, 0));
      core_ready = 1'b0;
      while (waited < 40) begin
        @(negedge clk);
        waited++;
        #1;
        if (err) break;
      end
      checkOutput("timeout_err", err, 1);
      checkOutput("timeout_cycles", waited, TO);
      checkOutput("timeout_busy", busy, 0);
      checkOutput("timeout_core_valid_n", core_valid_n, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
